// File: rtl/double_frame_buffer_if.sv
// Bus bundle for double_frame_buffer: ray-tracer write port, display read port,
// and the swap/clear control handshake.
interface double_frame_buffer_if #(
  parameter int AW      = 18,
  parameter int COLOR_W = 12
);
  logic [AW-1:0]      wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_en;
  logic               wr_ready;
  logic [AW-1:0]      rd_addr;
  logic               rd_en;
  logic [COLOR_W-1:0] rd_data;
  logic               rd_valid;
  logic               frame_start;
  logic               swap_req;
  logic               swap_done;
  logic               clear_req;
  logic [COLOR_W-1:0] clear_color;
  logic               busy;
  logic               front_sel;

  modport master (
    output wr_addr, wr_data, wr_en, rd_addr, rd_en,
           frame_start, swap_req, clear_req, clear_color,
    input  wr_ready, rd_data, rd_valid, swap_done, busy, front_sel
  );

  modport slave (
    input  wr_addr, wr_data, wr_en, rd_addr, rd_en,
           frame_start, swap_req, clear_req, clear_color,
    output wr_ready, rd_data, rd_valid, swap_done, busy, front_sel
  );
endinterface

// File: rtl/double_frame_buffer.sv
// Two-bank frame buffer: the ray tracer fills the back bank while the display
// reads the front bank; banks exchange only on a vertical-blank pulse.
module double_frame_buffer #(
  parameter int H_PIXELS = 512,
  parameter int V_PIXELS = 384,
  parameter int COLOR_W  = 12
) (
  input logic             clk,
  input logic             rst_n,
  double_frame_buffer_if.slave bus
);
  localparam int XW    = $clog2(H_PIXELS);
  localparam int YW    = $clog2(V_PIXELS);
  localparam int AW    = XW + YW;
  localparam int DEPTH = 2 ** AW;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] CLEAR      = 2'd1;
  localparam logic [1:0] WAIT_VSYNC = 2'd2;

  logic [1:0]         state_reg;
  logic               front_sel_reg;
  logic               swap_pend_reg;
  logic               swap_done_reg;
  logic [XW-1:0]      clr_x_reg;
  logic [YW-1:0]      clr_y_reg;
  logic [COLOR_W-1:0] clr_color_reg;
  logic               rd_valid_reg;
  logic               rd_sel_reg;
  logic               rd_zero_reg;

  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               back_sel;
  logic               clr_last;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (int'(a[XW-1:0]) < H_PIXELS) && (int'(a[AW-1:XW]) < V_PIXELS);
  endfunction

  assign back_sel = ~front_sel_reg;
  assign clr_last = (clr_x_reg == X_LAST) && (clr_y_reg == Y_LAST);

  // The clear engine and the ray tracer never write in the same state, so one port suffices.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (state_reg == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = {clr_y_reg, clr_x_reg};
      mem_wdata = clr_color_reg;
    end else if (state_reg == IDLE && bus.wr_en && in_range(bus.wr_addr)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      front_sel_reg <= 1'b0;
      swap_pend_reg <= 1'b0;
      swap_done_reg <= 1'b0;
      clr_x_reg     <= '0;
      clr_y_reg     <= '0;
      clr_color_reg <= '0;
      rd_valid_reg  <= 1'b0;
      rd_sel_reg    <= 1'b0;
      rd_zero_reg   <= 1'b1;
    end else begin
      swap_done_reg <= 1'b0;
      rd_valid_reg  <= bus.rd_en;
      if (bus.rd_en) begin
        rd_sel_reg  <= front_sel_reg;
        rd_zero_reg <= !in_range(bus.rd_addr);
      end
      case (state_reg)
        IDLE: begin
          if (bus.clear_req) begin
            clr_color_reg <= bus.clear_color;
            clr_x_reg     <= '0;
            clr_y_reg     <= '0;
            swap_pend_reg <= bus.swap_req;
            state_reg     <= CLEAR;
          end else if (bus.swap_req) begin
            state_reg <= WAIT_VSYNC;
          end
        end
        CLEAR: begin
          if (clr_last) begin
            state_reg     <= swap_pend_reg ? WAIT_VSYNC : IDLE;
            swap_pend_reg <= 1'b0;
            clr_x_reg     <= '0;
            clr_y_reg     <= '0;
          end else if (clr_x_reg == X_LAST) begin
            clr_x_reg <= '0;
            clr_y_reg <= clr_y_reg + 1'b1;
          end else begin
            clr_x_reg <= clr_x_reg + 1'b1;
          end
        end
        WAIT_VSYNC: begin
          if (bus.frame_start) begin
            front_sel_reg <= ~front_sel_reg;
            swap_done_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Both banks are read every access; the bank choice is applied after the RAM register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [COLOR_W-1:0] mem [DEPTH];
    logic [COLOR_W-1:0] q_reg;
    always_ff @(posedge clk) begin
      if (mem_we && (back_sel == 1'(gi)))
        mem[mem_waddr] <= mem_wdata;
      if (bus.rd_en)
        q_reg <= mem[bus.rd_addr];
    end
  end

  assign bus.rd_data   = rd_zero_reg ? '0 : (rd_sel_reg ? g_bank[1].q_reg : g_bank[0].q_reg);
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.swap_done = swap_done_reg;
  assign bus.front_sel = front_sel_reg;
  assign bus.wr_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_double_frame_buffer.sv
// Directed bench for double_frame_buffer: an 8x4 instance for the main flows and
// a 6x3 instance for out-of-range addresses and non-power-of-two clear sweeps.
module tb_double_frame_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  double_frame_buffer_if #(.AW(5), .COLOR_W(12)) bus1();
  double_frame_buffer_if #(.AW(5), .COLOR_W(12)) bus2();

  double_frame_buffer #(.H_PIXELS(8), .V_PIXELS(4), .COLOR_W(12)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  double_frame_buffer #(.H_PIXELS(6), .V_PIXELS(3), .COLOR_W(12)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct { logic [11:0] data; int cyc; } rd_exp_t;
  rd_exp_t q1[$];
  rd_exp_t q2[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [11:0] mdl [2][32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read1(input logic [4:0] a, input logic [11:0] e);
    bus1.rd_en = 1'b1;
    bus1.rd_addr = a;
    q1.push_back('{e, cyc + 1});
    step();
  endtask

  task automatic read2(input logic [4:0] a, input logic [11:0] e);
    bus2.rd_en = 1'b1;
    bus2.rd_addr = a;
    q2.push_back('{e, cyc + 1});
    step();
  endtask

  always @(posedge clk) begin : mon1
    rd_exp_t e;
    #1;
    if (bus1.rd_valid === 1'b1) begin
      if (q1.size() == 0) check("rd1_spurious", 1, 0);
      else begin
        e = q1.pop_front();
        check("rd1_latency", cyc, e.cyc);
        check("rd1_data", bus1.rd_data, e.data);
        $display("dut1 read cycle %0d data 0x%0h", cyc, bus1.rd_data);
      end
    end
  end

  always @(posedge clk) begin : mon2
    rd_exp_t e;
    #1;
    if (bus2.rd_valid === 1'b1) begin
      if (q2.size() == 0) check("rd2_spurious", 1, 0);
      else begin
        e = q2.pop_front();
        check("rd2_latency", cyc, e.cyc);
        check("rd2_data", bus2.rd_data, e.data);
        $display("dut2 read cycle %0d data 0x%0h", cyc, bus2.rd_data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int bad;
    bus1.wr_addr = '0; bus1.wr_data = '0; bus1.wr_en = 0; bus1.rd_addr = '0; bus1.rd_en = 0;
    bus1.frame_start = 0; bus1.swap_req = 0; bus1.clear_req = 0; bus1.clear_color = '0;
    bus2.wr_addr = '0; bus2.wr_data = '0; bus2.wr_en = 0; bus2.rd_addr = '0; bus2.rd_en = 0;
    bus2.frame_start = 0; bus2.swap_req = 0; bus2.clear_req = 0; bus2.clear_color = '0;

    // Reset values appear before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", bus1.busy, 0);
    check("rst_wr_ready", bus1.wr_ready, 1);
    check("rst_front_sel", bus1.front_sel, 0);
    check("rst_rd_valid", bus1.rd_valid, 0);
    check("rst_rd_data", bus1.rd_data, 0);
    check("rst_swap_done", bus1.swap_done, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Write, swap with frame_start three cycles later, read back
    bus1.wr_en = 1; bus1.wr_addr = 5'd10; bus1.wr_data = 12'hABC;
    step();
    mdl[1][10] = 12'hABC;
    bus1.wr_en = 0;
    bus1.swap_req = 1;
    step();
    bus1.swap_req = 0;
    check("wait_busy", bus1.busy, 1);
    check("wait_wr_ready", bus1.wr_ready, 0);
    check("wait_swap_done", bus1.swap_done, 0);
    step();
    step();
    bus1.frame_start = 1;
    step();
    bus1.frame_start = 0;
    check("swap1_front_sel", bus1.front_sel, 1);
    check("swap1_done", bus1.swap_done, 1);
    check("swap1_busy", bus1.busy, 0);
    step();
    check("swap1_done_pulse", bus1.swap_done, 0);
    read1(5'd10, mdl[1][10]);
    bus1.rd_en = 0;

    // Clear back bank 0; writes during the sweep must be dropped, reads still served
    bus1.clear_req = 1; bus1.clear_color = 12'hF00;
    step();
    bus1.clear_req = 0; bus1.clear_color = 12'h555;
    bus1.wr_en = 1; bus1.wr_addr = 5'd0; bus1.wr_data = 12'h777;
    bus1.rd_en = 1; bus1.rd_addr = 5'd10;
    q1.push_back('{mdl[1][10], cyc + 1});
    n = 0; bad = 0;
    while (bus1.busy === 1'b1 && n < 100) begin
      if (bus1.wr_ready !== 1'b0) bad++;
      n++;
      step();
      bus1.rd_en = 0;
    end
    bus1.wr_en = 0;
    check("clear1_cycles", n, 32);
    check("clear1_wr_ready_low", bad, 0);
    for (int i = 0; i < 32; i++) mdl[0][i] = 12'hF00;
    bus1.swap_req = 1;
    step();
    bus1.swap_req = 0;
    bus1.frame_start = 1;
    step();
    bus1.frame_start = 0;
    check("swap2_front_sel", bus1.front_sel, 0);
    check("swap2_done", bus1.swap_done, 1);
    for (int i = 0; i < 32; i++) read1(5'(i), mdl[0][i]);
    bus1.rd_en = 0;

    // clear+swap together; frame_start during the sweep must not swap
    bus1.clear_req = 1; bus1.swap_req = 1; bus1.clear_color = 12'h0F0;
    step();
    bus1.clear_req = 0; bus1.swap_req = 0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      bus1.frame_start = (i == 5 || i == 31);
      if (bus1.swap_done !== 1'b0) bad++;
      step();
    end
    bus1.frame_start = 0;
    check("pend_front_sel", bus1.front_sel, 0);
    check("pend_busy", bus1.busy, 1);
    step();
    step();
    check("pend_still_waiting", bus1.front_sel, 0);
    bus1.frame_start = 1;
    step();
    bus1.frame_start = 0;
    check("pend_swap_front_sel", bus1.front_sel, 1);
    check("pend_swap_done", bus1.swap_done, 1);
    check("pend_no_early_done", bad, 0);
    for (int i = 0; i < 32; i++) mdl[1][i] = 12'h0F0;
    read1(5'd0, mdl[1][0]);
    read1(5'd10, mdl[1][10]);
    read1(5'd31, mdl[1][31]);
    bus1.rd_en = 0;

    // Reset at clear pixel 10 of back bank 0
    bus1.clear_req = 1; bus1.clear_color = 12'h0A5;
    step();
    bus1.clear_req = 0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus1.busy, 0);
    check("abort_front_sel", bus1.front_sel, 0);
    check("abort_wr_ready", bus1.wr_ready, 1);
    check("abort_rd_data", bus1.rd_data, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) mdl[0][i] = 12'h0A5;
    bus1.wr_en = 1; bus1.wr_addr = 5'd20; bus1.wr_data = 12'h3C3;
    check("post_rst_wr_ready", bus1.wr_ready, 1);
    step();
    bus1.wr_en = 0;
    mdl[1][20] = 12'h3C3;
    read1(5'd0, mdl[0][0]);
    read1(5'd9, mdl[0][9]);
    read1(5'd10, mdl[0][10]);
    read1(5'd31, mdl[0][31]);
    bus1.rd_en = 0;

    // frame_start coincident with swap_req is ignored
    bus1.swap_req = 1; bus1.frame_start = 1;
    step();
    bus1.swap_req = 0; bus1.frame_start = 0;
    check("coinc_front_sel", bus1.front_sel, 0);
    check("coinc_swap_done", bus1.swap_done, 0);
    check("coinc_busy", bus1.busy, 1);
    step();
    bus1.frame_start = 1;
    step();
    bus1.frame_start = 0;
    check("coinc_swap_front_sel", bus1.front_sel, 1);
    check("coinc_swap_done2", bus1.swap_done, 1);
    read1(5'd20, mdl[1][20]);
    read1(5'd21, mdl[1][21]);
    bus1.rd_en = 0;

    // 6x3 instance: x=6 and y=3 are outside the visible area
    bus2.wr_en = 1; bus2.wr_addr = {2'd0, 3'd6}; bus2.wr_data = 12'h123;
    step();
    bus2.wr_en = 0;
    read2({2'd0, 3'd6}, 12'h000);
    read2({2'd3, 3'd0}, 12'h000);
    bus2.rd_en = 0;
    bus2.clear_req = 1; bus2.clear_color = 12'h0C3;
    step();
    bus2.clear_req = 0;
    n = 0;
    while (bus2.busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check("clear2_cycles", n, 18);
    bus2.swap_req = 1;
    step();
    bus2.swap_req = 0;
    bus2.frame_start = 1;
    step();
    bus2.frame_start = 0;
    check("swap3_front_sel", bus2.front_sel, 1);
    read2({2'd0, 3'd0}, 12'h0C3);
    read2({2'd2, 3'd5}, 12'h0C3);
    read2({2'd2, 3'd6}, 12'h000);
    read2({2'd1, 3'd7}, 12'h000);
    bus2.rd_en = 0;

    step();
    step();
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
